// File: rtl/mem_port_arbiter.sv
// Shared 32-bit memory port arbiter between the I-cache fill side and the D side.
// Grants one owner at a time, lingers one cycle after each beat, and flags stalled beats.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_re,
    input  logic [14:0] i_addr,
    output logic        i_rdy,
    output logic [31:0] i_rd_data,
    input  logic        d_re,
    input  logic        d_we,
    input  logic [14:0] d_addr,
    input  logic [31:0] d_wr_data,
    output logic        d_rdy,
    output logic [31:0] d_rd_data,
    output logic        mem_re,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_rdy,
    output logic        gnt_i,
    output logic        gnt_d,
    output logic        err_timeout
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT_I = 3'd1,
        GRANT_D = 3'd2,
        HOLD_I  = 3'd3,
        HOLD_D  = 3'd4
    } state_t;

    localparam logic        SIDE_I     = 1'b0;
    localparam logic        SIDE_D     = 1'b1;
    localparam logic [3:0]  TIMEOUT_C  = 4'(TIMEOUT);
    localparam logic [3:0]  TIMEOUT_M1 = 4'(TIMEOUT - 1);

    state_t      state_r;
    state_t      state_s;
    logic        last_r;
    logic [3:0]  wd_cnt_r;
    logic        err_r;
    logic        d_req_s;
    logic        in_grant_s;

    assign d_req_s    = d_re | d_we;
    assign in_grant_s = (state_r == GRANT_I) || (state_r == GRANT_D);

    // Next-state selection: round-robin on ties in IDLE, owner keeps priority in HOLD.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_re && d_req_s) begin
                    state_s = (last_r == SIDE_I) ? GRANT_D : GRANT_I;
                end else if (i_re) begin
                    state_s = GRANT_I;
                end else if (d_req_s) begin
                    state_s = GRANT_D;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT_I: begin
                if (!i_re) begin
                    state_s = IDLE;
                end else if (mem_rdy) begin
                    state_s = HOLD_I;
                end else begin
                    state_s = GRANT_I;
                end
            end
            GRANT_D: begin
                if (!d_req_s) begin
                    state_s = IDLE;
                end else if (mem_rdy) begin
                    state_s = HOLD_D;
                end else begin
                    state_s = GRANT_D;
                end
            end
            HOLD_I: begin
                if (i_re) begin
                    state_s = GRANT_I;
                end else if (d_req_s) begin
                    state_s = GRANT_D;
                end else begin
                    state_s = IDLE;
                end
            end
            HOLD_D: begin
                if (d_req_s) begin
                    state_s = GRANT_D;
                end else if (i_re) begin
                    state_s = GRANT_I;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Port steering: owner drives the memory port; rdy only reaches a still-requesting owner.
    always_comb begin
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 15'd0;
        mem_wr_data = 32'd0;
        i_rdy       = 1'b0;
        d_rdy       = 1'b0;
        case (state_r)
            GRANT_I, HOLD_I: begin
                mem_re   = i_re;
                mem_addr = i_addr;
                if (state_r == GRANT_I) begin
                    i_rdy = mem_rdy & i_re;
                end else begin
                    i_rdy = 1'b0;
                end
            end
            GRANT_D, HOLD_D: begin
                mem_we      = d_we;
                mem_re      = d_re & ~d_we;
                mem_addr    = d_addr;
                mem_wr_data = d_wr_data;
                if (state_r == GRANT_D) begin
                    d_rdy = mem_rdy & d_req_s;
                end else begin
                    d_rdy = 1'b0;
                end
            end
            default: begin
                mem_re = 1'b0;
            end
        endcase
    end

    // State and last-served side registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            last_r  <= SIDE_I;
        end else begin
            state_r <= state_s;
            if (state_r == GRANT_I && state_s == HOLD_I) begin
                last_r <= SIDE_I;
            end else if (state_r == GRANT_D && state_s == HOLD_D) begin
                last_r <= SIDE_D;
            end else begin
                last_r <= last_r;
            end
        end
    end

    // Watchdog: counts stalled grant cycles; the counter saturates so the flag cannot re-arm.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_r <= 4'd0;
            err_r    <= 1'b0;
        end else if ((state_s != state_r) || mem_rdy) begin
            wd_cnt_r <= 4'd0;
            err_r    <= err_r;
        end else if (in_grant_s) begin
            if (wd_cnt_r != TIMEOUT_C) begin
                wd_cnt_r <= wd_cnt_r + 4'd1;
            end else begin
                wd_cnt_r <= wd_cnt_r;
            end
            if (wd_cnt_r == TIMEOUT_M1) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end else begin
            wd_cnt_r <= wd_cnt_r;
            err_r    <= err_r;
        end
    end

    assign gnt_i       = (state_r == GRANT_I) || (state_r == HOLD_I);
    assign gnt_d       = (state_r == GRANT_D) || (state_r == HOLD_D);
    assign err_timeout = err_r;
    assign i_rd_data   = mem_rd_data;
    assign d_rd_data   = mem_rd_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transactions against a 4-cycle memory model;
// expected beats are queued at issue time and checked by a monitor on each rdy pulse.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_re, d_re, d_we;
    logic [14:0] i_addr, d_addr;
    logic [31:0] d_wr_data;
    logic        i_rdy, d_rdy;
    logic [31:0] i_rd_data, d_rd_data;
    logic        mem_re, mem_we;
    logic [14:0] mem_addr;
    logic [31:0] mem_wr_data, mem_rd_data;
    logic        mem_rdy;
    logic        gnt_i, gnt_d, err_timeout;

    logic        mem_en, force_rdy;
    logic [1:0]  lat;

    typedef struct packed {
        logic        side;
        logic [14:0] addr;
        logic [1:0]  strobe;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_port_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .i_re(i_re), .i_addr(i_addr), .i_rdy(i_rdy), .i_rd_data(i_rd_data),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wr_data(d_wr_data),
        .d_rdy(d_rdy), .d_rd_data(d_rd_data),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_rdy(mem_rdy),
        .gnt_i(gnt_i), .gnt_d(gnt_d), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Memory model: a beat completes in the 4th consecutive strobed cycle.
    assign mem_rdy     = force_rdy | (mem_en & (mem_re | mem_we) & (lat == 2'd3));
    assign mem_rd_data = 32'hC0DE_0000 | {17'd0, mem_addr};

    always @(posedge clk) begin
        if (rst || !(mem_re || mem_we) || mem_rdy) lat <= 2'd0;
        else lat <= lat + 2'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic side, input logic [14:0] addr, input logic [1:0] strobe,
                        input logic [31:0] wdata);
        exp_t e;
        e.side   = side;
        e.addr   = addr;
        e.strobe = strobe;
        e.wdata  = wdata;
        e.rdata  = 32'hC0DE_0000 | {17'd0, addr};
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for a beat on one side; optionally checks I ownership while waiting.
    task automatic wait_rdy(input logic side, input logic hold_i, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (side ? d_rdy : i_rdy) begin
                seen = 1'b1;
            end else if (hold_i) begin
                check({name, "_gnt_i"}, 32'(gnt_i), 32'd1);
                check({name, "_no_d_rdy"}, 32'(d_rdy), 32'd0);
            end
        end
        check({name, "_rdy_seen"}, 32'(seen), 32'd1);
        tick();
    endtask

    // Scoreboard monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (i_rdy || d_rdy) begin
                check("rdy_exclusive", 32'(i_rdy & d_rdy), 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rdy: got i_rdy=%0b d_rdy=%0b expected no beat",
                             i_rdy, d_rdy);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rdy_side", 32'(d_rdy), 32'(mon_e.side));
                    check("mem_addr", 32'(mem_addr), 32'(mon_e.addr));
                    check("strobes", 32'({mem_re, mem_we}), 32'(mon_e.strobe));
                    if (mon_e.strobe[0]) check("wr_data", mem_wr_data, mon_e.wdata);
                    check("rd_data", mon_e.side ? d_rd_data : i_rd_data, mon_e.rdata);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; i_re = 1'b0; d_re = 1'b0; d_we = 1'b0;
        i_addr = 15'd0; d_addr = 15'd0; d_wr_data = 32'd0;
        mem_en = 1'b1; force_rdy = 1'b0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_gnt_i", 32'(gnt_i), 32'd0);
        check("rst_gnt_d", 32'(gnt_d), 32'd0);
        check("rst_strobes", 32'({mem_re, mem_we}), 32'd0);
        check("rst_rdys", 32'({i_rdy, d_rdy}), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);

        // Two-beat I fill
        tick();
        i_re = 1'b1; i_addr = 15'h0010; push(1'b0, 15'h0010, 2'b10, 32'd0);
        @(negedge clk);
        wait_rdy(1'b0, 1'b1, "fill_b1");
        i_addr = 15'h0011; push(1'b0, 15'h0011, 2'b10, 32'd0);
        wait_rdy(1'b0, 1'b1, "fill_b2");
        i_re = 1'b0;
        @(negedge clk);
        check("fill_hold_gnt_i", 32'(gnt_i), 32'd1);
        @(negedge clk);
        check("fill_idle_gnt_i", 32'(gnt_i), 32'd0);
        check("fill_idle_re", 32'(mem_re), 32'd0);
        tick();

        // Tie: D first, I after the D hold
        i_re = 1'b1; i_addr = 15'h0020; d_re = 1'b1; d_addr = 15'h0120;
        push(1'b1, 15'h0120, 2'b10, 32'd0); push(1'b0, 15'h0020, 2'b10, 32'd0);
        @(negedge clk); @(negedge clk);
        check("tie1_gnt_d", 32'(gnt_d), 32'd1);
        check("tie1_gnt_i", 32'(gnt_i), 32'd0);
        check("tie1_addr", 32'(mem_addr), 32'h0120);
        wait_rdy(1'b1, 1'b0, "tie1_d");
        d_re = 1'b0;
        @(negedge clk);
        check("tie1_hold_d", 32'(gnt_d), 32'd1);
        @(negedge clk);
        check("tie1_then_i", 32'(gnt_i), 32'd1);
        check("tie1_i_addr", 32'(mem_addr), 32'h0020);
        wait_rdy(1'b0, 1'b0, "tie1_i");
        i_re = 1'b0;
        tick();

        // D write raised between the two I beats
        i_re = 1'b1; i_addr = 15'h0030; push(1'b0, 15'h0030, 2'b10, 32'd0);
        @(negedge clk);
        wait_rdy(1'b0, 1'b1, "dw_b1");
        i_addr = 15'h0031; d_re = 1'b1; d_we = 1'b1; d_addr = 15'h0100; d_wr_data = 32'hDEADBEEF;
        push(1'b0, 15'h0031, 2'b10, 32'd0); push(1'b1, 15'h0100, 2'b01, 32'hDEADBEEF);
        wait_rdy(1'b0, 1'b1, "dw_b2");
        i_re = 1'b0;
        wait_rdy(1'b1, 1'b0, "dw_d");
        d_re = 1'b0; d_we = 1'b0;
        tick();

        // Tie with last = D: I first
        i_re = 1'b1; i_addr = 15'h0040; d_re = 1'b1; d_addr = 15'h0140;
        push(1'b0, 15'h0040, 2'b10, 32'd0); push(1'b1, 15'h0140, 2'b10, 32'd0);
        @(negedge clk); @(negedge clk);
        check("tie2_gnt_i", 32'(gnt_i), 32'd1);
        check("tie2_gnt_d", 32'(gnt_d), 32'd0);
        wait_rdy(1'b0, 1'b0, "tie2_i");
        i_re = 1'b0;
        wait_rdy(1'b1, 1'b0, "tie2_d");
        d_re = 1'b0;
        tick();

        // Reset during GRANT_D
        mem_en = 1'b0; d_we = 1'b1; d_addr = 15'h0070; d_wr_data = 32'h12345678;
        @(negedge clk); @(negedge clk);
        check("rmid_gnt_d", 32'(gnt_d), 32'd1);
        check("rmid_we", 32'(mem_we), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; d_we = 1'b0; force_rdy = 1'b1;
        @(negedge clk);
        check("rmid_gnts", 32'({gnt_i, gnt_d}), 32'd0);
        check("rmid_strobes", 32'({mem_re, mem_we}), 32'd0);
        check("rmid_rdys", 32'({i_rdy, d_rdy}), 32'd0);
        tick();
        force_rdy = 1'b0; mem_en = 1'b1;
        tick();

        // Tie after reset: D first again
        i_re = 1'b1; i_addr = 15'h0007; d_re = 1'b1; d_addr = 15'h0170;
        push(1'b1, 15'h0170, 2'b10, 32'd0); push(1'b0, 15'h0007, 2'b10, 32'd0);
        @(negedge clk); @(negedge clk);
        check("tie3_gnt_d", 32'(gnt_d), 32'd1);
        wait_rdy(1'b1, 1'b0, "tie3_d");
        d_re = 1'b0;
        wait_rdy(1'b0, 1'b0, "tie3_i");
        i_re = 1'b0;
        tick();

        // Abort, then a late mem_rdy
        mem_en = 1'b0; i_re = 1'b1; i_addr = 15'h0050;
        @(negedge clk); @(negedge clk);
        check("abort_gnt_i", 32'(gnt_i), 32'd1);
        check("abort_re", 32'(mem_re), 32'd1);
        tick();
        i_re = 1'b0;
        @(negedge clk);
        check("abort_re_drop", 32'(mem_re), 32'd0);
        tick();
        force_rdy = 1'b1;
        @(negedge clk);
        check("abort_idle", 32'(gnt_i), 32'd0);
        check("abort_late_rdys", 32'({i_rdy, d_rdy}), 32'd0);
        tick();
        force_rdy = 1'b0;

        // Watchdog: D never completes
        d_re = 1'b1; d_addr = 15'h0060;
        repeat (16) @(negedge clk);
        check("wd_before", 32'(err_timeout), 32'd0);
        check("wd_gnt_d", 32'(gnt_d), 32'd1);
        @(negedge clk);
        check("wd_set", 32'(err_timeout), 32'd1);
        tick();
        d_re = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("wd_sticky", 32'(err_timeout), 32'd1);
        check("wd_released", 32'(gnt_d), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("wd_cleared", 32'(err_timeout), 32'd0);

        repeat (2) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
